// File: rtl/ll_input.sv
// Lunar-lander keypad front end: synchronizes and debounces the pushbuttons,
// decodes accepted keys into thrust digits or display selection, and produces the update tick.
module ll_input #(
    parameter int          DEBOUNCE    = 4,
    parameter int          TICK_DIV    = 25,
    parameter logic [15:0] THRUST_INIT = 16'h0005
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [20:0] pb,
    output logic        key_valid,
    output logic [4:0]  key_code,
    output logic [15:0] thrust_o,
    output logic        thrust_wr,
    output logic [1:0]  disp_sel,
    output logic        tick
);

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE);
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

    logic [20:0] sync1_q, sync2_q;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  cand_q;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [4:0]  code;
    logic        pressed;

    always_ff @(posedge hz100) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pb;
            sync2_q <= sync1_q;
        end
    end

    // Priority encoder: later (higher-index) bits override earlier ones.
    always_comb begin
        code = 5'd0;
        for (int i = 0; i < 21; i++) begin
            if (sync2_q[i]) code = 5'(i);
        end
        pressed = |sync2_q;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 5'd0;
            key_valid <= 1'b0;
            key_code  <= 5'd0;
            thrust_o  <= THRUST_INIT;
            thrust_wr <= 1'b0;
            disp_sel  <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            thrust_wr <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q <= ARMING;
                        cnt_q   <= 4'd1;
                        cand_q  <= code;
                    end
                end
                ARMING: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (code != cand_q) begin
                        cand_q <= code;
                        cnt_q  <= 4'd1;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= HELD;
                        key_valid <= 1'b1;
                        key_code  <= cand_q;
                        if (cand_q <= 5'd9) begin
                            thrust_o  <= {12'h000, cand_q[3:0]};
                            thrust_wr <= 1'b1;
                        end else begin
                            case (cand_q)
                                5'd19:   disp_sel <= 2'd0;
                                5'd18:   disp_sel <= 2'd1;
                                5'd17:   disp_sel <= 2'd2;
                                5'd16:   disp_sel <= 2'd3;
                                default: ;
                            endcase
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HELD: begin
                    // Extra buttons while held are deliberately ignored.
                    if (!pressed) begin
                        state_q <= RELEASING;
                        cnt_q   <= 4'd1;
                    end
                end
                RELEASING: begin
                    if (pressed) begin
                        state_q <= HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tick is registered from the next count so it is high exactly while the count sits at its last value.
    always_comb begin
        tcnt_d = (tcnt_q == TICK_LAST) ? 8'd0 : tcnt_q + 8'd1;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            tcnt_q <= 8'd0;
            tick   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tick   <= (tcnt_d == TICK_LAST);
        end
    end

endmodule

// File: doc/ll_input.md
LL_INPUT -- requirements
Module: ll_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4: consecutive stable synchronized cycles required to accept a press or a release (legal range 1-15).
REQ-002 The block SHALL have parameter TICK_DIV, default 25: hz100 cycles per lander update tick (legal range 2-255).
REQ-003 The block SHALL have parameter THRUST_INIT, default 16'h0005: reset value of thrust_o (BCD).
REQ-004 Port hz100  input  1  system clock; all state SHALL update on its rising edge only.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port pb  input  21  raw asynchronous pushbuttons, active-high; pb[9:0] = digits 0-9, pb[19]=Z, pb[18]=Y, pb[17]=X, pb[16]=W.
REQ-007 Port key_valid  output  1  one-cycle pulse per accepted press.
REQ-008 Port key_code  output  5  index of accepted button, valid while key_valid=1, held afterwards.
REQ-009 Port thrust_o  output  16  BCD thrust for ll_memory thrust_n, format 16'h000d.
REQ-010 Port thrust_wr  output  1  one-cycle pulse when thrust_o takes a new digit value.
REQ-011 Port disp_sel  output  2  displayed quantity: 0=altitude, 1=velocity, 2=fuel, 3=thrust.
REQ-012 Port tick  output  1  one-cycle pulse every TICK_DIV cycles; drives the lander update enable.

Function
REQ-013 pb SHALL pass through a two-flop synchronizer before any other logic; no combinational path from pb to any output.
REQ-014 Encoder: code = highest-index asserted synchronized bit; pressed = OR of all 21 synchronized bits.
REQ-015 FSM states SHALL be IDLE, ARMING, HELD, RELEASING, with a 4-bit stability counter cnt.
REQ-016 IDLE: pressed=1 -> ARMING, cnt=1, latch code as candidate; else stay.
REQ-017 ARMING: pressed=0 -> IDLE; code != candidate -> stay, candidate=code, cnt=1; code == candidate and cnt==DEBOUNCE -> HELD with key_valid=1 in the following cycle; else cnt+1.
REQ-018 HELD: pressed=0 -> RELEASING, cnt=1; any pressed change including a second button SHALL be ignored.
REQ-019 RELEASING: pressed=1 -> HELD; pressed=0 and cnt==DEBOUNCE -> IDLE; else cnt+1.
REQ-020 Press latency: pb stable from edge k -> key_valid high in exactly the cycle after edge k+2+DEBOUNCE; exactly one pulse per press regardless of hold length.
REQ-021 On accepted code 0-9: thrust_o SHALL equal {12'h000, code[3:0]} in the same cycle key_valid is high, and thrust_wr SHALL be high that cycle.
REQ-022 On accepted code 19/18/17/16: disp_sel SHALL become 0/1/2/3 respectively, visible in the key_valid cycle; thrust_o unchanged, thrust_wr=0.
REQ-023 On any other accepted code (10-15, 20): key_valid SHALL pulse; thrust_o, disp_sel unchanged; thrust_wr=0.
REQ-024 Re-accepting the current thrust digit SHALL still pulse thrust_wr.
REQ-025 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick=1 exactly when counter==TICK_DIV-1; counter is independent of the FSM.

Reset
REQ-026 While reset=1 at a rising edge: FSM=IDLE, cnt=0, synchronizer flops=0, tick counter=0, key_valid=0, key_code=0, thrust_wr=0, tick=0, thrust_o=THRUST_INIT, disp_sel=0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the pending press; a button still held after reset release SHALL be accepted as a new press after the full REQ-020 latency.
REQ-028 First tick after reset release SHALL occur TICK_DIV cycles after the first non-reset edge.

Verification
REQ-029 Reset, then pb[7]=1 held 50 cycles -> one key_valid with key_code=7, thrust_o=16'h0007, thrust_wr=1, at cycle 2+DEBOUNCE; no further pulses.
REQ-030 pb[3] pulsed for DEBOUNCE-1 cycles, gaps of 10 cycles, repeated 5 times -> no key_valid; thrust_o stays 16'h0005.
REQ-031 Press pb[18], release, press pb[16] -> disp_sel 0->1->3; thrust_wr never asserted; thrust_o unchanged.
REQ-032 Hold pb[2], then add pb[9] while held -> key_code=2 only; release both, press pb[9] -> key_code=9, thrust_o=16'h0009.
REQ-033 Free run 100 cycles with TICK_DIV=25 -> tick high on cycles 25, 50, 75, 100 only; reset at cycle 60 -> next tick at cycle 60+25.
REQ-034 Reset asserted 2 cycles before key_valid would fire for pb[4], held 1 cycle, pb[4] kept high -> no pulse at the original time; single pulse 2+DEBOUNCE cycles after reset release, thrust_o=16'h0004.
